alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 188 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage for a tiny 4-register machine.
// It decodes one instruction at a time and presents registered operands
// to an external combinational ALU. It then captures the result and writes
// it back. One instruction completes every three cycles: IDLE -> EXEC -> WB.
module alu_issue_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [9:0] instr,
  output logic       instr_ready,
  output logic [9:0] alu_a,
  output logic [9:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [9:0] alu_result,
  input  logic       alu_halt,
  output logic       wb_valid,
  output logic [1:0] wb_addr,
  output logic [9:0] wb_data,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [9:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_WB     = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // Sign-extend the 2-bit immediate field to the 10-bit datapath width.
  function automatic logic [9:0] sext_imm2(input logic [1:0] imm);
    sext_imm2 = {{8{imm[1]}}, imm};
  endfunction

  // Instruction fields
  logic [2:0] op_s;
  logic       imm_sel_s;
  logic [1:0] rd_s;
  logic [1:0] rs_s;
  logic [1:0] rt_s;

  assign op_s      = instr[9:7];
  assign imm_sel_s = instr[6];
  assign rd_s      = instr[5:4];
  assign rs_s      = instr[3:2];
  assign rt_s      = instr[1:0];

  // State and registered outputs
  state_t      state_q,       state_d;
  logic [9:0]  alu_a_q,       alu_a_d;
  logic [9:0]  alu_b_q,       alu_b_d;
  logic [2:0]  alu_ctrl_q,    alu_ctrl_d;
  logic [1:0]  rd_q,          rd_d;
  logic        instr_ready_q, instr_ready_d;
  logic        wb_valid_q,    wb_valid_d;
  logic [1:0]  wb_addr_q,     wb_addr_d;
  logic [9:0]  wb_data_q,     wb_data_d;
  logic        halted_q,      halted_d;
  logic [9:0]  rf_q [4];
  logic [9:0]  rf_d [4];

  // Register file reads; r0 is hard-wired to zero regardless of storage
  logic [9:0]  rs_val_s;
  logic [9:0]  rt_val_s;
  logic [9:0]  operand_b_s;
  logic        accept_s;

  assign rs_val_s    = (rs_s == 2'd0) ? 10'd0 : rf_q[rs_s];
  assign rt_val_s    = (rt_s == 2'd0) ? 10'd0 : rf_q[rt_s];
  assign operand_b_s = imm_sel_s ? sext_imm2(rt_s) : rt_val_s;

  // A handshake only counts in IDLE. There, instr_ready is high by construction.
  assign accept_s = instr_valid & instr_ready_q & (state_q == S_IDLE);

  // Next-state, operand and write-back computation for the issue FSM
  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    rd_d          = rd_q;
    instr_ready_d = instr_ready_q;
    wb_valid_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    halted_d      = halted_q;
    for (int i = 0; i < 4; i++) begin
      rf_d[i] = rf_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          alu_a_d       = rs_val_s;
          alu_b_d       = operand_b_s;
          alu_ctrl_d    = op_s;
          rd_d          = rd_s;
          instr_ready_d = 1'b0;
          state_d       = S_EXEC;
        end else begin
          instr_ready_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_EXEC: begin
        instr_ready_d = 1'b0;
        if (alu_halt) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          wb_valid_d = 1'b1;
          wb_addr_d  = rd_q;
          wb_data_d  = alu_result;
          state_d    = S_WB;
        end
      end

      S_WB: begin
        // A write to r0 still pulses wb_valid, but it never reaches storage.
        if (wb_addr_q != 2'd0) begin
          rf_d[wb_addr_q] = wb_data_q;
        end else begin
          rf_d[0] = 10'd0;
        end
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end

      S_HALTED: begin
        halted_d      = 1'b1;
        instr_ready_d = 1'b0;
        state_d       = S_HALTED;
      end

      default: begin
        halted_d      = 1'b0;
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State, outputs and register file update with synchronous reset priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      alu_a_q       <= 10'd0;
      alu_b_q       <= 10'd0;
      alu_ctrl_q    <= 3'd0;
      rd_q          <= 2'd0;
      instr_ready_q <= 1'b1;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= 2'd0;
      wb_data_q     <= 10'd0;
      halted_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= 10'd0;
      end
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      rd_q          <= rd_d;
      instr_ready_q <= instr_ready_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      halted_q      <= halted_d;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign halted      = halted_q;
  assign dbg_data    = (dbg_sel == 2'd0) ? 10'd0 : rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU attached.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [9:0] instr;
  logic       instr_ready;
  logic [9:0] alu_a;
  logic [9:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [9:0] alu_result;
  logic       alu_halt;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [9:0] wb_data;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [9:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_halt    (alu_halt),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .halted      (halted),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shift-left-1, 110 halt
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = alu_a << 1;
      default: alu_result = 10'd0;
    endcase
  end
  assign alu_halt = (alu_ctrl == 3'b110);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic chk_dbg(input string tag, input logic [1:0] sel, input logic [9:0] expected);
    dbg_sel = sel;
    #1;
    chk(tag, dbg_data, expected);
  endtask

  // Issue one instruction and follow it through EXEC and WB
  task automatic do_instr(input string tag, input logic [9:0] iw,
                          input logic [9:0] ea, input logic [9:0] eb, input logic [2:0] ec,
                          input logic [1:0] ead, input logic [9:0] ed);
    chk({tag, "_rdy_idle"}, {9'd0, instr_ready}, 10'd1);
    instr = iw;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = 10'd0;
    chk({tag, "_alu_a"}, alu_a, ea);
    chk({tag, "_alu_b"}, alu_b, eb);
    chk({tag, "_alu_ctrl"}, {7'd0, alu_ctrl}, {7'd0, ec});
    chk({tag, "_rdy_exec"}, {9'd0, instr_ready}, 10'd0);
    chk({tag, "_wbv_exec"}, {9'd0, wb_valid}, 10'd0);
    tick();
    chk({tag, "_wbv"}, {9'd0, wb_valid}, 10'd1);
    chk({tag, "_wb_addr"}, {8'd0, wb_addr}, {8'd0, ead});
    chk({tag, "_wb_data"}, wb_data, ed);
    chk({tag, "_rdy_wb"}, {9'd0, instr_ready}, 10'd0);
    tick();
    chk({tag, "_wbv_done"}, {9'd0, wb_valid}, 10'd0);
    chk({tag, "_rdy_back"}, {9'd0, instr_ready}, 10'd1);
    chk_dbg({tag, "_dbg"}, ead, (ead == 2'd0) ? 10'd0 : ed);
  endtask

  logic [9:0]  prog [3];
  logic [9:0]  wb_seen [3];
  logic [11:0] rdy_m, acc_m, wb_m;
  int          idx, npulse, nready, nhalt_lo;
  logic        r_s, v_s;

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 10'd0;
    dbg_sel = 2'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", {9'd0, instr_ready}, 10'd1);
    chk("rst_alu_a", alu_a, 10'd0);
    chk("rst_alu_b", alu_b, 10'd0);
    chk("rst_ctrl", {7'd0, alu_ctrl}, 10'd0);
    chk("rst_wbv", {9'd0, wb_valid}, 10'd0);
    chk("rst_halted", {9'd0, halted}, 10'd0);
    chk_dbg("rst_r1", 2'd1, 10'd0);

    // Immediate add, negative immediate, shift, subtract, xor with negative immediate
    do_instr("addi_r1", 10'b000_1_01_00_01, 10'd0, 10'd1, 3'b000, 2'd1, 10'd1);
    do_instr("addi_r2", 10'b000_1_10_00_11, 10'd0, 10'h3FF, 3'b000, 2'd2, 10'h3FF);
    do_instr("sll_r1", 10'b101_0_01_01_00, 10'd1, 10'd0, 3'b101, 2'd1, 10'd2);
    do_instr("sub_r3", 10'b001_0_11_01_10, 10'd2, 10'h3FF, 3'b001, 2'd3, 10'd3);
    do_instr("xori_r2", 10'b100_1_10_11_10, 10'd3, 10'h3FE, 3'b100, 2'd2, 10'h3FD);

    // Back-to-back handshake with instr_valid held high
    prog[0] = 10'b000_1_01_00_01;   // r1 = 1
    prog[1] = 10'b000_0_10_01_01;   // r2 = r1 + r1 = 2
    prog[2] = 10'b001_0_11_10_01;   // r3 = r2 - r1 = 1
    rdy_m = 12'd0; acc_m = 12'd0; wb_m = 12'd0;
    idx = 0; npulse = 0;
    instr = prog[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      r_s = instr_ready;
      v_s = instr_valid;
      rdy_m[c] = r_s;
      tick();
      if (r_s && v_s) begin
        acc_m[c] = 1'b1;
        idx++;
        if (idx < 3) begin
          instr = prog[idx];
        end else begin
          instr_valid = 1'b0;
          instr = 10'd0;
        end
      end
      if (wb_valid) begin
        wb_m[c] = 1'b1;
        if (npulse < 3) wb_seen[npulse] = wb_data;
        npulse++;
      end
    end
    chk("hs_ready_mask", {10'd0, rdy_m[11:10]}, 10'd3);
    chk("hs_ready_mask_lo", rdy_m[9:0], 10'h249);
    chk("hs_accept_mask", acc_m[9:0], 10'h049);
    chk("hs_wb_mask", wb_m[9:0], 10'h092);
    chk("hs_wb_count", npulse[9:0], 10'd3);
    chk("hs_wb0", wb_seen[0], 10'd1);
    chk("hs_wb1", wb_seen[1], 10'd2);
    chk("hs_wb2", wb_seen[2], 10'd1);
    chk_dbg("hs_r3", 2'd3, 10'd1);

    // Write to r0 pulses but is discarded
    do_instr("w_r0", 10'b000_1_00_00_01, 10'd0, 10'd1, 3'b000, 2'd0, 10'd1);

    // Reset during WB of r1 = r2 + 1
    instr = 10'b000_1_01_10_01;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("mid_alu_a", alu_a, 10'd2);
    tick();
    chk("mid_wbv", {9'd0, wb_valid}, 10'd1);
    chk("mid_wb_data", wb_data, 10'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_wbv", {9'd0, wb_valid}, 10'd0);
    chk("mid_rst_ready", {9'd0, instr_ready}, 10'd1);
    chk("mid_rst_alu_a", alu_a, 10'd0);
    chk("mid_rst_alu_b", alu_b, 10'd0);
    chk("mid_rst_wb_data", wb_data, 10'd0);
    chk("mid_rst_wb_addr", {8'd0, wb_addr}, 10'd0);
    chk_dbg("mid_rst_r1", 2'd1, 10'd0);
    chk_dbg("mid_rst_r2", 2'd2, 10'd0);
    chk_dbg("mid_rst_r3", 2'd3, 10'd0);

    // Reset and valid on the same edge: nothing accepted
    instr = 10'b011_1_01_00_01;
    instr_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_valid = 1'b0;
    chk("rstv_ready", {9'd0, instr_ready}, 10'd1);
    chk("rstv_ctrl", {7'd0, alu_ctrl}, 10'd0);
    chk("rstv_alu_b", alu_b, 10'd0);

    // Halt: absorbing state, ignores instr_valid
    instr = 10'b110_0_00_00_00;
    instr_valid = 1'b1;
    tick();
    instr = 10'b000_1_01_00_01;
    chk("halt_ctrl", {7'd0, alu_ctrl}, 10'd6);
    tick();
    chk("halt_halted", {9'd0, halted}, 10'd1);
    chk("halt_wbv", {9'd0, wb_valid}, 10'd0);
    npulse = 0; nready = 0; nhalt_lo = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (wb_valid) npulse++;
      if (instr_ready) nready++;
      if (!halted) nhalt_lo++;
    end
    instr_valid = 1'b0;
    chk("halt_no_wb", npulse[9:0], 10'd0);
    chk("halt_no_ready", nready[9:0], 10'd0);
    chk("halt_stays", nhalt_lo[9:0], 10'd0);
    chk("halt_ctrl_held", {7'd0, alu_ctrl}, 10'd6);
    chk_dbg("halt_r1", 2'd1, 10'd0);

    // Reset out of HALTED, then the machine runs again
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt_halted", {9'd0, halted}, 10'd0);
    chk("unhalt_ready", {9'd0, instr_ready}, 10'd1);
    do_instr("post_r1", 10'b000_1_01_00_01, 10'd0, 10'd1, 3'b000, 2'd1, 10'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
